fp16_acc_seq: RTL and testbench
===============================

Name: fp16_acc_seq

Overview:
- Sequential FP16 accumulator placed directly downstream of the combinational FP16 multiplier in the MAC datapath.
- Accepts a stream of products (1 sign, 5 exponent, 10 fraction bits, bias 15) over a valid/ready handshake and sums them into an internal accumulator using a multi-cycle add.
- On the beat flagged last, it presents the final sum downstream and clears itself for the next dot product.

Parameters:
EXP_W, 5, exponent width
FRAC_W, 10, stored fraction width (hidden 1 implicit)
GUARD_W, 3, extra low-order bits kept through align/add, truncated at writeback

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_data  in  16  product operand {S, E[4:0], F[9:0]}
in_valid  in  1  in_data/in_last valid
in_last  in  1  final term of the current dot product
in_ready  out  1  block can accept a beat
out_data  out  16  accumulated sum
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - acc = 16'h0000; state = IDLE.
  - out_data = 0, out_valid = 0, in_ready = 0 while rst is high.
- Number rules, matching the multiplier format:
  - Exponent 0 means zero regardless of fraction. No denormals, inf or NaN.
  - All rounding is truncation.
- States: IDLE, ALIGN, ADD, NORM, WB, OUT.
- IDLE:
  - in_ready = 1, asserted combinationally from state.
  - When in_valid & in_ready: register operand B = in_data and last_q = in_last; go to ALIGN.
- ALIGN:
  - Order the operands so X has the larger magnitude (compare {E,F}); the other is Y. On a tie, X = acc.
  - Form mantissas {1,F,GUARD_W zeros}; a zero operand has mantissa 0.
  - Shift Y right by d = Ex − Ey. If d ≥ FRAC_W + GUARD_W + 1, Y contributes 0.
  - Result exponent = Ex; if X is zero, use Ey.
- ADD:
  - Equal signs: add. Otherwise subtract, Mx − My. Sign = X sign.
  - Carry out: shift right 1, exponent +1.
- NORM, one cycle per step:
  - Mantissa zero: result is +0 (16'h0000); go to WB.
  - MSB set: go to WB.
  - Otherwise shift left 1 and decrement the exponent. If the exponent reaches 0, the result flushes to 16'h0000; go to WB.
- WB:
  - Exponent overflow (≥ 31) saturates to {S, 5'h1E, 10'h3FF}.
  - acc = {S, E, mantissa bits below the hidden bit, top FRAC_W only}.
  - If last_q, go to OUT; else go to IDLE.
- OUT:
  - out_valid = 1 and out_data = acc; both held stable until out_ready.
  - On out_valid & out_ready: acc = 0, out_valid = 0, go to IDLE.
  - in_ready = 0 throughout OUT.
- Latency, beat accepted at cycle T:
  - ALIGN at T+1, ADD at T+2, NORM at T+3…T+3+k (k = left shifts, 0..13), WB next.
  - Without shifts: WB at T+4, out_valid at T+5, in_ready again at T+5 for a non-last beat.
- Stalls and special cases:
  - in_valid low in IDLE: no state change.
  - A single-beat stream with in_last = 1 outputs 0 + operand.
- Reset mid-operation, in any state: abort immediately, discard the partial sum, outputs go to reset values. No beat is consumed until rst deasserts and the block is in IDLE.

Test Plan:
- 0x3C00, then 0x4000 with in_last → out_data 0x4200 (3.0), out_valid exactly 5 cycles after the last accept; acc is 0 afterwards (next single beat 0x3C00 last → 0x3C00).
- 0x3E00, then 0xBC00 last → 0x3800 (0.5), one NORM shift (out_valid at T+6); 0x3C00 + 0xBC00 last → 0x0000.
- 0x7BFF + 0x7BFF last → saturates to 0x7BFF; 0xFBFF + 0xFBFF → 0xFBFF.
- 0x6400 + 0x0400 last (d = 24) → 0x6400; 0x0000 + 0xC200 last → 0xC200; operand with exponent 0 and fraction ≠ 0 is treated as zero.
- Hold out_ready = 0 for 5 cycles in OUT → out_data/out_valid stable, in_ready = 0; the beat driven meanwhile is not consumed and is accepted only after the handshake.
- Assert rst during NORM of a multi-shift add → out_valid = 0, in_ready = 0 at once; after release, 0x3C00 last → 0x3C00 (no stale sum).

Source files
------------

// File: rtl/fp16_acc_seq_if.sv
// ---------------------------------------------------------------------------
// fp16_acc_seq_if
// Stream bundle that links the FP16 accumulator to the multiplier upstream
// and to the consumer of finished dot products downstream.
//
//   in_data   : product operand {S, E[4:0], F[9:0]}
//   in_valid  : in_data / in_last are valid
//   in_last   : this beat is the final term of the dot product
//   in_ready  : accumulator can take a beat this cycle
//   out_data  : accumulated sum
//   out_valid : out_data is valid
//   out_ready : downstream takes out_data this cycle
//
// master : the side that produces products and consumes sums
// slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface fp16_acc_seq_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/fp16_acc_seq.sv
// ---------------------------------------------------------------------------
// fp16_acc_seq
// Multi-cycle FP16 accumulator. Each accepted product is added into an
// internal accumulator through ALIGN / ADD / NORM / WB steps. When the beat
// flagged last has been folded in, the sum is offered downstream and the
// accumulator clears once it has been taken.
//
// Number format: 1 sign, EXP_W exponent, FRAC_W fraction, bias 15.
// Exponent zero means zero; no denormals, inf or NaN. Rounding is
// truncation throughout.
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : fp16_acc_seq_if.slave (in_* product stream, out_* sum stream)
// ---------------------------------------------------------------------------
module fp16_acc_seq #(
    parameter int EXP_W   = 5,
    parameter int FRAC_W  = 10,
    parameter int GUARD_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    fp16_acc_seq_if.slave  bus
);

    localparam int DATA_W = 1 + EXP_W + FRAC_W;
    localparam int MANT_W = 1 + FRAC_W + GUARD_W;

    localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(FRAC_W + GUARD_W + 1);
    localparam logic [EXP_W:0]   EXP_SAT   = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        WB,
        OUT
    } stateType;

    stateType state;
    stateType stateNext;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] opB;
    logic              lastQ;

    logic [MANT_W-1:0] mantX;
    logic [MANT_W-1:0] mantY;
    logic              effSubR;
    logic              signR;
    logic [EXP_W:0]    expR;
    logic [MANT_W-1:0] mantR;

    logic              inReady;
    logic              outValid;

    logic              swapOps;
    logic [DATA_W-1:0] xOp;
    logic [DATA_W-1:0] yOp;
    logic [EXP_W-1:0]  xExp;
    logic [EXP_W-1:0]  yExp;
    logic              xZero;
    logic              yZero;
    logic [MANT_W-1:0] mantXRaw;
    logic [MANT_W-1:0] mantYRaw;
    logic [EXP_W-1:0]  expDiff;
    logic [MANT_W-1:0] alignMantY;
    logic [EXP_W:0]    alignExp;
    logic              alignSub;
    logic              alignSign;

    logic [MANT_W:0]   sumFull;
    logic [EXP_W:0]    expDec;
    logic [DATA_W-1:0] wbValue;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outValid ? acc : '0;

    // State register. Reset drops straight back to IDLE from any state, so a
    // partially built sum never survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake outputs. in_ready is also gated by rst so the
    // upstream sees "not ready" for the whole time reset is held, even though
    // the state register already reads IDLE.
    always_comb begin
        stateNext = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            IDLE: begin
                inReady = !rst;
                if (bus.in_valid && inReady) begin
                    stateNext = ALIGN;
                end
            end
            ALIGN: stateNext = ADD;
            ADD:   stateNext = NORM;
            NORM: begin
                if (mantR == '0 || mantR[MANT_W-1]) begin
                    stateNext = WB;
                end else if (expDec == '0) begin
                    stateNext = WB;
                end
            end
            WB: stateNext = lastQ ? OUT : IDLE;
            OUT: begin
                outValid = 1'b1;
                if (bus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand ordering and alignment. X is the operand with the larger
    // magnitude (ties keep the accumulator as X) so the later subtraction
    // Mx - My can never go negative. Y is shifted right by the exponent gap;
    // beyond the full mantissa width it cannot contribute and becomes zero.
    // Because X >= Y in {E,F}, Ex >= Ey and the difference never wraps.
    always_comb begin
        swapOps   = opB[DATA_W-2:0] > acc[DATA_W-2:0];
        xOp       = swapOps ? opB : acc;
        yOp       = swapOps ? acc : opB;
        xExp      = xOp[DATA_W-2 -: EXP_W];
        yExp      = yOp[DATA_W-2 -: EXP_W];
        xZero     = (xExp == '0);
        yZero     = (yExp == '0);
        mantXRaw  = xZero ? '0 : {1'b1, xOp[FRAC_W-1:0], {GUARD_W{1'b0}}};
        mantYRaw  = yZero ? '0 : {1'b1, yOp[FRAC_W-1:0], {GUARD_W{1'b0}}};
        expDiff   = xExp - yExp;
        alignMantY = (expDiff >= MAX_SHIFT) ? '0 : (mantYRaw >> expDiff);
        alignExp  = {1'b0, (xZero ? yExp : xExp)};
        alignSub  = xOp[DATA_W-1] ^ yOp[DATA_W-1];
        alignSign = xOp[DATA_W-1];
    end

    // Mantissa add/subtract with one spare carry bit, the normalisation
    // exponent step, and the packed value written back to the accumulator.
    // An exponent that has climbed to all-ones saturates to the largest
    // finite magnitude instead of producing an infinity.
    always_comb begin
        sumFull = effSubR ? ({1'b0, mantX} - {1'b0, mantY})
                          : ({1'b0, mantX} + {1'b0, mantY});
        expDec  = expR - 1'b1;
        if (expR >= EXP_SAT) begin
            wbValue = {signR, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        end else begin
            wbValue = {signR, expR[EXP_W-1:0], mantR[MANT_W-2 -: FRAC_W]};
        end
    end

    // Datapath registers, advanced one step per FSM state. A zero mantissa or
    // an exponent that underflows during normalisation is forced to +0 here
    // so that writeback packs 16'h0000 with no special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            opB     <= '0;
            lastQ   <= 1'b0;
            mantX   <= '0;
            mantY   <= '0;
            effSubR <= 1'b0;
            signR   <= 1'b0;
            expR    <= '0;
            mantR   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && inReady) begin
                        opB   <= bus.in_data;
                        lastQ <= bus.in_last;
                    end
                end
                ALIGN: begin
                    mantX   <= mantXRaw;
                    mantY   <= alignMantY;
                    expR    <= alignExp;
                    signR   <= alignSign;
                    effSubR <= alignSub;
                end
                ADD: begin
                    if (sumFull[MANT_W]) begin
                        mantR <= sumFull[MANT_W:1];
                        expR  <= expR + 1'b1;
                    end else begin
                        mantR <= sumFull[MANT_W-1:0];
                    end
                end
                NORM: begin
                    if (mantR == '0) begin
                        expR  <= '0;
                        signR <= 1'b0;
                    end else if (!mantR[MANT_W-1]) begin
                        if (expDec == '0) begin
                            mantR <= '0;
                            expR  <= '0;
                            signR <= 1'b0;
                        end else begin
                            mantR <= mantR << 1;
                            expR  <= expDec;
                        end
                    end
                end
                WB: begin
                    acc <= wbValue;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        acc <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_acc_seq.sv
// ---------------------------------------------------------------------------
// tb_fp16_acc_seq
// Scoreboard bench for fp16_acc_seq. The driver pushes the hand-computed sum
// of each dot product when its last beat is accepted; an independent monitor
// pops an entry whenever out_valid rises and compares data, latency and
// in_ready, optionally stalling out_ready for a number of cycles.
// ---------------------------------------------------------------------------
module tb_fp16_acc_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp16_acc_seq_if bus ();

    fp16_acc_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] data;
        int          latency;
        int          acceptCycle;
        int          hold;
        string       name;
    } expT;

    expT scoreboard[$];

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;
    int lastHandshakeCycle = 0;

    // Free-running cycle number; stable between edges, read at negedges.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one beat and waits (bounded) for it to be accepted. For a last
    // beat with push set, the expected sum is queued for the monitor.
    task automatic applyStimulus(input logic [15:0] data, input bit last,
                                 input logic [15:0] expSum, input int expLat,
                                 input int hold, input string name,
                                 input bit push, output int accCycle);
        int waited;
        expT e;
        @(negedge clk);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
            accCycle = -1;
            bus.in_valid = 1'b0;
            return;
        end
        accCycle = cycleCnt;
        if (last && push) begin
            e.data        = expSum;
            e.latency     = expLat;
            e.acceptCycle = accCycle;
            e.hold        = hold;
            e.name        = name;
            scoreboard.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Monitor: pops one expectation on each rising out_valid.
    initial begin
        expT e;
        bit  prevValid;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
            end else begin
                if (bus.out_valid === 1'b1 && !prevValid) begin
                    if (scoreboard.size() == 0) begin
                        checkOutput("unexpected out_valid", 32'd1, 32'd0);
                    end else begin
                        e = scoreboard.pop_front();
                        checkOutput({e.name, " data"}, 32'(bus.out_data), 32'(e.data));
                        checkOutput({e.name, " latency"}, 32'(cycleCnt - e.acceptCycle),
                                    32'(e.latency));
                        checkOutput({e.name, " in_ready in OUT"}, 32'(bus.in_ready), 32'd0);
                        if (e.hold > 0) begin
                            bus.out_ready = 1'b0;
                            for (int i = 0; i < e.hold; i++) begin
                                @(negedge clk);
                                checkOutput({e.name, " stall out_valid"},
                                            32'(bus.out_valid), 32'd1);
                                checkOutput({e.name, " stall out_data"},
                                            32'(bus.out_data), 32'(e.data));
                                checkOutput({e.name, " stall in_ready"},
                                            32'(bus.in_ready), 32'd0);
                            end
                            bus.out_ready = 1'b1;
                        end
                        lastHandshakeCycle = cycleCnt;
                    end
                end
                prevValid = (bus.out_valid === 1'b1);
            end
        end
    end

    // Directed vectors; expected sums are computed by hand from the format.
    initial begin
        int a;
        int b;
        int w;
        rst           = 1'b1;
        bus.in_data   = 16'h0000;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        // 1.0 + 2.0 = 3.0, then the accumulator must be clear
        applyStimulus(16'h3C00, 0, 16'h0000, 0, 0, "sum3 b0", 0, a);
        applyStimulus(16'h4000, 1, 16'h4200, 5, 0, "sum3", 1, a);
        applyStimulus(16'h3C00, 1, 16'h3C00, 5, 0, "cleared", 1, a);

        // 1.5 - 1.0 = 0.5 with one normalise shift; 1.0 - 1.0 = +0
        applyStimulus(16'h3E00, 0, 16'h0000, 0, 0, "half b0", 0, a);
        applyStimulus(16'hBC00, 1, 16'h3800, 6, 0, "half", 1, a);
        applyStimulus(16'h3C00, 0, 16'h0000, 0, 0, "cancel b0", 0, a);
        applyStimulus(16'hBC00, 1, 16'h0000, 5, 0, "cancel", 1, a);

        // Overflow saturates to the largest finite value, both signs
        applyStimulus(16'h7BFF, 0, 16'h0000, 0, 0, "satpos b0", 0, a);
        applyStimulus(16'h7BFF, 1, 16'h7BFF, 5, 0, "satpos", 1, a);
        applyStimulus(16'hFBFF, 0, 16'h0000, 0, 0, "satneg b0", 0, a);
        applyStimulus(16'hFBFF, 1, 16'hFBFF, 5, 0, "satneg", 1, a);

        // Exponent gap of 24 drops the small operand; zero plus negative
        applyStimulus(16'h6400, 0, 16'h0000, 0, 0, "gap b0", 0, a);
        applyStimulus(16'h0400, 1, 16'h6400, 5, 0, "gap", 1, a);
        applyStimulus(16'h0000, 0, 16'h0000, 0, 0, "zeroneg b0", 0, a);
        applyStimulus(16'hC200, 1, 16'hC200, 5, 0, "zeroneg", 1, a);

        // Exponent 0 with a nonzero fraction counts as zero
        applyStimulus(16'h0155, 0, 16'h0000, 0, 0, "ezero b0", 0, a);
        applyStimulus(16'h3C00, 1, 16'h3C00, 5, 0, "ezero first", 1, a);
        applyStimulus(16'h3C00, 0, 16'h0000, 0, 0, "ezero2 b0", 0, a);
        applyStimulus(16'h8200, 1, 16'h3C00, 5, 0, "ezero second", 1, a);

        // 1.0 - 0.99951 = 2^-11: eleven normalise shifts
        applyStimulus(16'h3C00, 0, 16'h0000, 0, 0, "deep b0", 0, a);
        applyStimulus(16'hBBFF, 1, 16'h1000, 16, 0, "deep", 1, a);

        // Underflow while normalising flushes to +0 after two shifts
        applyStimulus(16'h0800, 0, 16'h0000, 0, 0, "flush b0", 0, a);
        applyStimulus(16'h87FF, 1, 16'h0000, 6, 0, "flush", 1, a);

        // out_ready stall: output held, next beat waits for the handshake
        applyStimulus(16'h4000, 1, 16'h4000, 5, 5, "stall", 1, a);
        applyStimulus(16'h3C00, 1, 16'h3C00, 5, 0, "after stall", 1, b);
        checkOutput("stalled beat accept cycle", 32'(b), 32'(lastHandshakeCycle + 1));

        // Reset in the middle of a multi-shift normalisation
        applyStimulus(16'h3C00, 0, 16'h0000, 0, 0, "abort b0", 0, a);
        applyStimulus(16'hBBFF, 1, 16'h0000, 0, 0, "abort b1", 0, a);
        while (cycleCnt < a + 6) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("abort out_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(16'h3C00, 1, 16'h3C00, 5, 0, "post reset", 1, a);

        w = 0;
        while (scoreboard.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
